// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage instruction pointer with sequential, jump, relative
// branch and call/return redirects backed by a small return-address stack.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned OFS_W       = 6,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic                                   iStall,
  input  logic                                   iJump,
  input  logic                                   iCall,
  input  logic                                   iRet,
  input  logic                                   iBranchTaken,
  input  logic [ADDR_W-1:0]                      iTarget,
  input  logic [OFS_W-1:0]                       iOffset,
  output logic [ADDR_W-1:0]                      oIP,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       oDepth,
  output logic                                   oStackFull,
  output logic                                   oStackEmpty,
  output logic                                   oOverflow,
  output logic                                   oUnderflow
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  ip_q, ip_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0]  ip_plus1;
  logic [ADDR_W-1:0]  ofs_sext;
  logic [PTR_W-1:0]   push_ptr;
  logic [PTR_W-1:0]   pop_ptr;
  logic               full;
  logic               empty;

  // Stack occupancy and pointer helpers; top of stack lives at depth-1.
  always_comb begin
    full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    empty    = (depth_q == DEPTH_W'(0));
    push_ptr = PTR_W'(depth_q);
    pop_ptr  = PTR_W'(depth_q - DEPTH_W'(1));
    ip_plus1 = ip_q + ADDR_W'(1);
    ofs_sext = ADDR_W'($signed(iOffset));
  end

  // Next-state selection: stall > ret > call > jump > branch > sequential.
  always_comb begin
    ip_d    = ip_plus1;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;

    if (iStall) begin
      ip_d = ip_q;
    end else if (iRet) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ip_d    = stack_q[pop_ptr];
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else if (iCall) begin
      ip_d = iTarget;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[push_ptr] = ip_plus1;
        depth_d           = depth_q + DEPTH_W'(1);
      end
    end else if (iJump) begin
      ip_d = iTarget;
    end else if (iBranchTaken) begin
      ip_d = ip_q + ofs_sext;
    end
  end

  // Control state: synchronous reset restores IP, depth and sticky flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip_q    <= ADDR_W'(RESET_ADDR);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not cleared by reset, but reset blocks any write.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      stack_q <= stack_d;
    end
  end

  assign oIP         = ip_q;
  assign oDepth      = depth_q;
  assign oOverflow   = ovf_q;
  assign oUnderflow  = unf_q;
  assign oStackFull  = full;
  assign oStackEmpty = empty;

endmodule
